// File: rtl/lc3_execute_stage.sv
// LC-3 execute stage: operand bypass, ALU, effective-address adder and the
// pipeline register feeding the memory-access and writeback stages.
module lc3_execute_stage #(
  parameter int DATA_W     = 16,
  parameter int REG_ADDR_W = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable_execute,
  input  logic [DATA_W-1:0]     IR,
  input  logic [5:0]            E_control,
  input  logic [DATA_W-1:0]     npc_out,
  input  logic                  Mem_Control,
  input  logic [1:0]            W_Control,
  input  logic [DATA_W-1:0]     VSR1,
  input  logic [DATA_W-1:0]     VSR2,
  input  logic                  bypass_alu_1,
  input  logic                  bypass_alu_2,
  input  logic                  bypass_mem_1,
  input  logic                  bypass_mem_2,
  input  logic [DATA_W-1:0]     Mem_Bypass_Val,
  output logic [REG_ADDR_W-1:0] sr1,
  output logic [REG_ADDR_W-1:0] sr2,
  output logic [DATA_W-1:0]     aluout,
  output logic [DATA_W-1:0]     pcout,
  output logic [DATA_W-1:0]     M_Data,
  output logic [REG_ADDR_W-1:0] dr,
  output logic [2:0]            NZP,
  output logic [DATA_W-1:0]     IR_Exec,
  output logic [1:0]            W_Control_out,
  output logic                  Mem_Control_out
);

  logic [3:0]        opcode;
  logic [1:0]        alu_control;
  logic [1:0]        pcselect1;
  logic              pcselect2;
  logic              op2select;
  logic [DATA_W-1:0] op1, op2, opb, alu_res, offset, base, addr;
  logic              is_alu_op;

  logic [DATA_W-1:0]     aluout_q, aluout_d;
  logic [DATA_W-1:0]     pcout_q, pcout_d;
  logic [DATA_W-1:0]     m_data_q, m_data_d;
  logic [REG_ADDR_W-1:0] dr_q, dr_d;
  logic [2:0]            nzp_q, nzp_d;
  logic [DATA_W-1:0]     ir_exec_q;
  logic [1:0]            w_control_q;
  logic                  mem_control_q;

  assign opcode      = IR[15:12];
  assign alu_control = E_control[5:4];
  assign pcselect1   = E_control[3:2];
  assign pcselect2   = E_control[1];
  assign op2select   = E_control[0];

  assign sr1 = IR[8:6];
  // Stores read the source data register through port 2
  assign sr2 = (opcode == 4'b0011 || opcode == 4'b0111 || opcode == 4'b1011) ? IR[11:9] : IR[2:0];

  // aluout here is the previous result, giving back-to-back forwarding
  assign op1 = bypass_alu_1 ? aluout_q : (bypass_mem_1 ? Mem_Bypass_Val : VSR1);
  assign op2 = bypass_alu_2 ? aluout_q : (bypass_mem_2 ? Mem_Bypass_Val : VSR2);
  assign opb = op2select ? op2 : {{(DATA_W-5){IR[4]}}, IR[4:0]};

  always_comb begin
    alu_res = '0;
    case (alu_control)
      2'b00:   alu_res = op1 + opb;
      2'b01:   alu_res = op1 & opb;
      2'b10:   alu_res = ~op1;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    offset = '0;
    case (pcselect1)
      2'b00:   offset = {{(DATA_W-11){IR[10]}}, IR[10:0]};
      2'b01:   offset = {{(DATA_W-9){IR[8]}}, IR[8:0]};
      2'b10:   offset = {{(DATA_W-6){IR[5]}}, IR[5:0]};
      default: offset = '0;
    endcase
  end

  assign base      = pcselect2 ? npc_out : op1;
  assign addr      = base + offset;
  assign is_alu_op = (opcode == 4'b0001 || opcode == 4'b0101 || opcode == 4'b1001);

  always_comb begin
    aluout_d = is_alu_op ? alu_res : addr;
    pcout_d  = addr;
    m_data_d = op2;
    dr_d     = '0;
    nzp_d    = 3'b000;
    case (opcode)
      4'b0001, 4'b0101, 4'b1001, 4'b0010, 4'b0110, 4'b1010, 4'b1110: dr_d = IR[11:9];
      default: dr_d = '0;
    endcase
    if (opcode == 4'b0000)      nzp_d = IR[11:9];
    else if (opcode == 4'b1100) nzp_d = 3'b111;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      aluout_q      <= '0;
      pcout_q       <= '0;
      m_data_q      <= '0;
      dr_q          <= '0;
      nzp_q         <= '0;
      ir_exec_q     <= '0;
      w_control_q   <= '0;
      mem_control_q <= 1'b0;
    end else if (enable_execute) begin
      aluout_q      <= aluout_d;
      pcout_q       <= pcout_d;
      m_data_q      <= m_data_d;
      dr_q          <= dr_d;
      nzp_q         <= nzp_d;
      ir_exec_q     <= IR;
      w_control_q   <= W_Control;
      mem_control_q <= Mem_Control;
    end
  end

  assign aluout          = aluout_q;
  assign pcout           = pcout_q;
  assign M_Data          = m_data_q;
  assign dr              = dr_q;
  assign NZP             = nzp_q;
  assign IR_Exec         = ir_exec_q;
  assign W_Control_out   = w_control_q;
  assign Mem_Control_out = mem_control_q;

endmodule

// File: tb/tb_lc3_execute_stage.sv
// Directed-vector bench for lc3_execute_stage with hand-computed expectations.
module tb_lc3_execute_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable_execute;
  logic [15:0] IR;
  logic [5:0]  E_control;
  logic [15:0] npc_out;
  logic        Mem_Control;
  logic [1:0]  W_Control;
  logic [15:0] VSR1, VSR2;
  logic        bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2;
  logic [15:0] Mem_Bypass_Val;
  logic [2:0]  sr1, sr2;
  logic [15:0] aluout, pcout, M_Data;
  logic [2:0]  dr, NZP;
  logic [15:0] IR_Exec;
  logic [1:0]  W_Control_out;
  logic        Mem_Control_out;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  lc3_execute_stage dut (
    .clock(clock), .reset(reset), .enable_execute(enable_execute), .IR(IR),
    .E_control(E_control), .npc_out(npc_out), .Mem_Control(Mem_Control),
    .W_Control(W_Control), .VSR1(VSR1), .VSR2(VSR2),
    .bypass_alu_1(bypass_alu_1), .bypass_alu_2(bypass_alu_2),
    .bypass_mem_1(bypass_mem_1), .bypass_mem_2(bypass_mem_2),
    .Mem_Bypass_Val(Mem_Bypass_Val), .sr1(sr1), .sr2(sr2), .aluout(aluout),
    .pcout(pcout), .M_Data(M_Data), .dr(dr), .NZP(NZP), .IR_Exec(IR_Exec),
    .W_Control_out(W_Control_out), .Mem_Control_out(Mem_Control_out)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // byp = {bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2}
  task automatic drive(input logic [15:0] ir, input logic [5:0] ectl, input logic [15:0] npc,
                       input logic [15:0] v1, input logic [15:0] v2, input logic [3:0] byp,
                       input logic [15:0] memv, input logic mc, input logic [1:0] wc);
    IR = ir; E_control = ectl; npc_out = npc; VSR1 = v1; VSR2 = v2;
    {bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2} = byp;
    Mem_Bypass_Val = memv; Mem_Control = mc; W_Control = wc;
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_aluout"}, aluout, 16'h0);
    check({tag, "_pcout"},  pcout, 16'h0);
    check({tag, "_mdata"},  M_Data, 16'h0);
    check({tag, "_dr"},     {13'h0, dr}, 16'h0);
    check({tag, "_nzp"},    {13'h0, NZP}, 16'h0);
    check({tag, "_irexec"}, IR_Exec, 16'h0);
    check({tag, "_wctl"},   {14'h0, W_Control_out}, 16'h0);
    check({tag, "_mctl"},   {15'h0, Mem_Control_out}, 16'h0);
  endtask

  initial begin
    reset = 1'b0; enable_execute = 1'b1;
    drive(16'h1261, 6'b000000, 16'h3000, 16'h1111, 16'h2222, 4'b0000, 16'h0, 1'b1, 2'b11);
    step(); step();
    check_all_zero("rst_en");

    reset = 1'b1;
    drive(16'h1261, 6'b000000, 16'h3000, 16'h0005, 16'h0000, 4'b0000, 16'h0, 1'b0, 2'b01);
    check("add_sr1", {13'h0, sr1}, 16'h0001);
    check("add_sr2", {13'h0, sr2}, 16'h0001);
    step();
    check("add_aluout", aluout, 16'h0006);
    check("add_dr", {13'h0, dr}, 16'h0001);
    check("add_nzp", {13'h0, NZP}, 16'h0000);
    check("add_wctl", {14'h0, W_Control_out}, 16'h0001);

    drive(16'h1261, 6'b000000, 16'h3000, 16'h00EF, 16'h0000, 4'b0000, 16'h0, 1'b0, 2'b01);
    step();
    check("add2_aluout", aluout, 16'h00F0);

    drive(16'h5042, 6'b010001, 16'h3000, 16'h0FFF, 16'h0000, 4'b0100, 16'h1234, 1'b0, 2'b01);
    step();
    check("and_byp_aluout", aluout, 16'h00F0);
    check("and_byp_mdata", M_Data, 16'h00F0);
    check("and_byp_dr", {13'h0, dr}, 16'h0000);

    drive(16'h5042, 6'b010001, 16'h3000, 16'h0FFF, 16'h0000, 4'b0101, 16'h1234, 1'b0, 2'b01);
    step();
    check("and_prio_aluout", aluout, 16'h00F0);

    drive(16'h96BF, 6'b100000, 16'h3000, 16'h0000, 16'h0000, 4'b0010, 16'h1234, 1'b0, 2'b01);
    step();
    check("not_mem_aluout", aluout, 16'hEDCB);
    check("not_mem_dr", {13'h0, dr}, 16'h0003);

    drive(16'h1000, 6'b000001, 16'h3000, 16'h0000, 16'h0001, 4'b1010, 16'h1234, 1'b0, 2'b01);
    step();
    check("add_alu1_aluout", aluout, 16'hEDCC);

    drive(16'h1261, 6'b110000, 16'h3000, 16'h0005, 16'h0000, 4'b0000, 16'h0, 1'b0, 2'b01);
    step();
    check("alu_zero_aluout", aluout, 16'h0000);

    drive(16'h0E05, 6'b000110, 16'h3001, 16'h7777, 16'h5555, 4'b0000, 16'h0, 1'b1, 2'b10);
    step();
    check("br_pcout", pcout, 16'h3006);
    check("br_aluout", aluout, 16'h3006);
    check("br_nzp", {13'h0, NZP}, 16'h0007);
    check("br_dr", {13'h0, dr}, 16'h0000);
    check("br_mdata", M_Data, 16'h5555);
    check("br_irexec", IR_Exec, 16'h0E05);
    check("br_wctl", {14'h0, W_Control_out}, 16'h0002);
    check("br_mctl", {15'h0, Mem_Control_out}, 16'h0001);

    enable_execute = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(16'h1261 + 16'(i), 6'b000000, 16'h4000, 16'h0100, 16'h0200, 4'b0000, 16'h0, 1'b0, 2'b01);
      step();
    end
    check("hold_aluout", aluout, 16'h3006);
    check("hold_pcout", pcout, 16'h3006);
    check("hold_mdata", M_Data, 16'h5555);
    check("hold_dr", {13'h0, dr}, 16'h0000);
    check("hold_nzp", {13'h0, NZP}, 16'h0007);
    check("hold_irexec", IR_Exec, 16'h0E05);
    check("hold_wctl", {14'h0, W_Control_out}, 16'h0002);
    check("hold_mctl", {15'h0, Mem_Control_out}, 16'h0001);
    enable_execute = 1'b1;

    drive(16'hE1FF, 6'b000110, 16'h3000, 16'h0000, 16'h0000, 4'b0000, 16'h0, 1'b0, 2'b01);
    step();
    check("lea_aluout", aluout, 16'h2FFF);
    check("lea_dr", {13'h0, dr}, 16'h0000);
    check("lea_nzp", {13'h0, NZP}, 16'h0000);

    drive(16'h7A7F, 6'b001000, 16'h3000, 16'h0000, 16'hBEEF, 4'b0000, 16'h0, 1'b1, 2'b00);
    check("str_sr2", {13'h0, sr2}, 16'h0005);
    check("str_sr1", {13'h0, sr1}, 16'h0001);
    step();
    check("str_pcout", pcout, 16'hFFFF);
    check("str_mdata", M_Data, 16'hBEEF);
    check("str_dr", {13'h0, dr}, 16'h0000);

    drive(16'h64C1, 6'b001000, 16'h3000, 16'hFFFF, 16'h0000, 4'b0000, 16'h0, 1'b0, 2'b01);
    check("ldr_sr2", {13'h0, sr2}, 16'h0001);
    step();
    check("ldr_wrap_pcout", pcout, 16'h0000);
    check("ldr_wrap_aluout", aluout, 16'h0000);
    check("ldr_dr", {13'h0, dr}, 16'h0002);

    drive(16'hC1C0, 6'b001100, 16'h3000, 16'h4000, 16'h0000, 4'b0000, 16'h0, 1'b0, 2'b00);
    step();
    check("jmp_pcout", pcout, 16'h4000);
    check("jmp_nzp", {13'h0, NZP}, 16'h0007);
    check("jmp_dr", {13'h0, dr}, 16'h0000);

    drive(16'h4C00, 6'b000010, 16'h3000, 16'h0000, 16'h0000, 4'b0000, 16'h0, 1'b0, 2'b01);
    step();
    check("jsr_pcout", pcout, 16'h2C00);

    drive(16'h3E00, 6'b000110, 16'h3000, 16'h0000, 16'h0000, 4'b0000, 16'h0, 1'b1, 2'b00);
    check("st_sr2", {13'h0, sr2}, 16'h0007);

    reset = 1'b0;
    drive(16'h1261, 6'b000000, 16'h3000, 16'h0005, 16'h1234, 4'b0000, 16'h0, 1'b1, 2'b11);
    step();
    check_all_zero("rst_mid");

    reset = 1'b1;
    step();
    check("rel_aluout", aluout, 16'h0006);
    check("rel_dr", {13'h0, dr}, 16'h0001);
    check("rel_irexec", IR_Exec, 16'h1261);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lc3_execute_stage.md
Name: lc3_execute_stage

Overview:
- Execute stage of the pipelined LC-3 core. Sits directly downstream of the decode stage.
- Consumes the decode-stage bundle (IR, E_control, npc_out, Mem_Control, W_Control) and register-file read values.
- Performs ALU operations and effective-address computation, with operand bypass from ALU and memory.
- Registers results for the writeback and memory-access stages, one cycle after an enabled input.

Parameters:
- DATA_W, 16, width of datapath, IR, PC and operands
- REG_ADDR_W, 3, register index width

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  synchronous reset, active-low
- enable_execute  input  1  stage advance; outputs update only when high
- IR  input  16  instruction from decode
- E_control  input  6  [5:4] alu_control, [3:2] pcselect1, [1] pcselect2, [0] op2select
- npc_out  input  16  PC+1 from decode
- Mem_Control  input  1  memory-stage control from decode
- W_Control  input  2  writeback-select from decode
- VSR1  input  16  register-file value at sr1
- VSR2  input  16  register-file value at sr2
- bypass_alu_1  input  1  replace operand 1 with current aluout
- bypass_alu_2  input  1  replace operand 2 with current aluout
- bypass_mem_1  input  1  replace operand 1 with Mem_Bypass_Val
- bypass_mem_2  input  1  replace operand 2 with Mem_Bypass_Val
- Mem_Bypass_Val  input  16  memory-stage forward value
- sr1  output  3  register-file read address 1 (combinational)
- sr2  output  3  register-file read address 2 (combinational)
- aluout  output  16  ALU result or effective address (registered)
- pcout  output  16  address-adder result (registered)
- M_Data  output  16  store data, post-bypass operand 2 (registered)
- dr  output  3  destination register (registered)
- NZP  output  3  branch condition mask (registered)
- IR_Exec  output  16  IR forwarded (registered)
- W_Control_out  output  2  registered W_Control
- Mem_Control_out  output  1  registered Mem_Control

Behaviour:

Combinational read addresses:
- sr1 = IR[8:6].
- sr2 = IR[11:9] for ST(0011), STR(0111), STI(1011); otherwise IR[2:0].

Operand selection:
- op1 = bypass_alu_1 ? aluout : bypass_mem_1 ? Mem_Bypass_Val : VSR1.
- op2 = same priority using bypass_alu_2 / bypass_mem_2 / VSR2.
- When both bypasses are set for one operand, ALU bypass wins.

ALU:
- opB = op2select ? op2 : sext(IR[4:0]).
- alu_control 00: op1+opB. 01: op1&opB. 10: ~op1. 11: 0.
- All arithmetic is modulo 2^16; no carry or overflow output.

Address adder:
- offset by pcselect1: 00 sext(IR[10:0]), 01 sext(IR[8:0]), 10 sext(IR[5:0]), 11 0.
- base = pcselect2 ? npc_out : op1.
- addr = base+offset, mod 2^16 (0xFFFF+1 wraps to 0x0000).

On rising clock edge:
- reset low: all registered outputs are 0, regardless of enable.
- Otherwise, with enable_execute high:
  - aluout = ALU result for ADD(0001), AND(0101), NOT(1001); addr for all other opcodes.
  - pcout = addr.
  - M_Data = op2.
  - dr = IR[11:9] for ADD, AND, NOT, LD, LDR, LDI, LEA; else 0.
  - NZP = IR[11:9] for BR(0000); 3'b111 for JMP(1100); else 0.
  - IR_Exec, W_Control_out, Mem_Control_out = their inputs.
- enable_execute low: all registered outputs hold.

Timing and boundary cases:
- Latency is exactly 1 cycle from an enabled sample to the output update.
- Bypass using aluout reads the value registered in the previous cycle (back-to-back dependency support).
- Reset asserted mid-stream clears state the same cycle; first enabled instruction after release appears one cycle later.
- Reset and enable both active: reset wins.

Test Plan:
- ADD imm: reset released; IR=0x1261 (ADD R1,R1,#1), E_control=6'b000000, VSR1=0x0005, enable=1 -> next cycle aluout=0x0006, dr=1, NZP=0, sr1=1 combinationally.
- AND reg with ALU bypass: IR=0x5042, E_control=6'b010001, bypass_alu_2=1, previous aluout=0x00F0, VSR1=0x0FFF -> aluout=0x00F0; with bypass_mem_2 also set, still 0x00F0.
- BR/LEA address: IR=0x0E05 (BRnzp +5), npc_out=0x3001, E_control=6'b000110 -> pcout=0x3006, NZP=3'b111, dr=0. Then IR=0xE1FF (LEA R0,-1), npc=0x3000 -> aluout=0x2FFF, dr=0.
- Store and wrap: IR=0x7A7F (STR R5,R1,#-1), E_control=6'b001000, VSR1=0x0000, VSR2=0xBEEF -> sr2=5, pcout=0xFFFF, M_Data=0xBEEF, dr=0.
- Enable hold: after a valid result, drop enable_execute for 3 cycles while changing all inputs -> all registered outputs unchanged.
- Reset mid-operation: drive reset=0 with enable=1 and nonzero inputs -> every registered output 0 next edge. Release reset -> next enabled instruction appears after 1 cycle.
